// File: rtl/bsg_cgol_readout.sv
// -----------------------------------------------------------------------------
// bsg_cgol_readout
//
// Read side of the Game of Life cell array. On a start handshake the whole
// board is copied into a snapshot register, then the snapshot is streamed
// out one row per valid/ready transfer, rows 0..board_height_p-1 in order.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   start_v_i      request to snapshot and stream the board
//   start_ready_o  idle, a start will be accepted
//   board_i        live cell states, bit [r*board_width_p + c] = row r, col c
//   v_o            output row valid
//   ready_i        consumer accepts the row when v_o & ready_i
//   data_o         current row, data_o[c] = column c
//   row_o          index of the current row
//   last_o         current row is the final row (qualified by v_o)
//   busy_o         frame in progress
//   done_o         one-cycle pulse after the final row handshake
// -----------------------------------------------------------------------------
module bsg_cgol_readout #(
    parameter int board_width_p  = 8,
    parameter int board_height_p = 8,
    localparam int row_width_lp  = (board_height_p > 1) ? $clog2(board_height_p) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    start_v_i,
    output logic                                    start_ready_o,
    input  logic [board_width_p*board_height_p-1:0] board_i,
    output logic                                    v_o,
    input  logic                                    ready_i,
    output logic [board_width_p-1:0]                data_o,
    output logic [row_width_lp-1:0]                 row_o,
    output logic                                    last_o,
    output logic                                    busy_o,
    output logic                                    done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [row_width_lp-1:0] last_row_lp = row_width_lp'(board_height_p - 1);

    state_e                                    state_q, state_d;
    logic [board_width_p*board_height_p-1:0]   snap_q,  snap_d;
    logic [row_width_lp-1:0]                   row_q,   row_d;
    logic                                      done_q,  done_d;
    logic                                      last_row;

    assign last_row = (row_q == last_row_lp);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    // NOTE: the snapshot is reset along with the control state so data_o reads
    // zero out of reset instead of leaking whatever powered up in the flops.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            snap_q  <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every output of this block gets a default before the case, which
    // is what keeps it purely combinational (no inferred latches).
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_v_i) begin
                    snap_d  = board_i;
                    row_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Start requests arriving here are dropped, not queued.
                if (ready_i) begin
                    if (last_row) begin
                        // Row counter parks on the final row; no wrap.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + row_width_lp'(1);
                    end
                end
            end
        endcase
    end

    // Row select from the snapshot. Driven from registers only, so ready_i
    // never reaches any output combinationally and backpressure holds data.
    always_comb begin
        data_o = '0;
        for (int r = 0; r < board_height_p; r++) begin
            if (row_q == row_width_lp'(r)) begin
                data_o = snap_q[r*board_width_p +: board_width_p];
            end
        end
    end

    assign v_o           = (state_q == SEND);
    assign busy_o        = (state_q == SEND);
    assign start_ready_o = (state_q == IDLE);
    assign row_o         = row_q;
    // Gated so a parked counter (or a 1-row board) does not flag last while idle.
    assign last_o        = (state_q == SEND) && last_row;
    assign done_o        = done_q;

endmodule

// File: tb/tb_bsg_cgol_readout.sv
module tb_bsg_cgol_readout;

    localparam int W = 4;
    localparam int H = 3;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          start_v_i;
    logic          start_ready_o;
    logic [W*H-1:0] board_i;
    logic          v_o;
    logic          ready_i;
    logic [W-1:0]  data_o;
    logic [1:0]    row_o;
    logic          last_o;
    logic          busy_o;
    logic          done_o;

    int n_tests  = 0;
    int n_failed = 0;

    bsg_cgol_readout #(
        .board_width_p (W),
        .board_height_p(H)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .start_v_i    (start_v_i),
        .start_ready_o(start_ready_o),
        .board_i      (board_i),
        .v_o          (v_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .row_o        (row_o),
        .last_o       (last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed beat: {v, busy, start_ready, data, row, last, done}.
    // data/row are only meaningful while v_o is high, so they are masked otherwise.
    function automatic logic [10:0] obs();
        return {v_o, busy_o, start_ready_o,
                v_o ? data_o : 4'h0, v_o ? row_o : 2'h0, last_o, done_o};
    endfunction

    function automatic logic [10:0] e(input logic v, input logic [3:0] d,
                                     input logic [1:0] r, input logic l, input logic dn);
        return {v, v, ~v, d, r, l, dn};
    endfunction

    // Drive inputs just after a falling edge, let one rising edge pass,
    // and return at the next falling edge where outputs are sampled.
    task automatic tick(input logic s, input logic [W*H-1:0] b, input logic r);
        start_v_i = s;
        board_i   = b;
        ready_i   = r;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        start_v_i = 1'b1;
        ready_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            board_i = 12'($urandom);
            @(negedge clk_i);
            n_tests++;
            if ({obs(), data_o, row_o} !== {e(0, 4'h0, 2'd0, 0, 0), 4'h0, 2'h0}) begin
                n_failed++;
                $display("FAIL reset cyc %0d: got %h/%h/%h, want %h/0/0",
                         i, obs(), data_o, row_o, e(0, 4'h0, 2'd0, 0, 0));
            end
        end
        reset_n_i = 1'b1;
        tick(0, 12'h000, 1);
    endtask

    task automatic test_basic();
        logic          st [5] = '{1, 0, 0, 0, 0};
        logic [10:0]   ex [5] = '{e(1, 4'hC, 2'd0, 0, 0), e(1, 4'h5, 2'd1, 0, 0),
                                  e(1, 4'hA, 2'd2, 1, 0), e(0, 4'h0, 2'd0, 0, 1),
                                  e(0, 4'h0, 2'd0, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            tick(st[i], 12'hA5C, 1);
            n_tests++;
            if (obs() !== ex[i]) begin
                n_failed++;
                $display("FAIL basic beat %0d: got %h, want %h", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic          st [6] = '{1, 0, 0, 0, 0, 0};
        logic          rd [6] = '{1, 1, 0, 0, 1, 1};
        logic [10:0]   ex [6] = '{e(1, 4'hC, 2'd0, 0, 0), e(1, 4'h5, 2'd1, 0, 0),
                                  e(1, 4'h5, 2'd1, 0, 0), e(1, 4'h5, 2'd1, 0, 0),
                                  e(1, 4'hA, 2'd2, 1, 0), e(0, 4'h0, 2'd0, 0, 1)};
        for (int i = 0; i < 6; i++) begin
            tick(st[i], 12'hA5C, rd[i]);
            n_tests++;
            if (obs() !== ex[i]) begin
                n_failed++;
                $display("FAIL backpressure beat %0d: got %h, want %h", i, obs(), ex[i]);
            end
        end
        tick(0, 12'hA5C, 1);
    endtask

    task automatic test_snapshot();
        logic          st [5] = '{1, 1, 0, 0, 0};
        logic [11:0]   bd [5] = '{12'hA5C, 12'h000, 12'h000, 12'h000, 12'h000};
        logic [10:0]   ex [5] = '{e(1, 4'hC, 2'd0, 0, 0), e(1, 4'h5, 2'd1, 0, 0),
                                  e(1, 4'hA, 2'd2, 1, 0), e(0, 4'h0, 2'd0, 0, 1),
                                  e(0, 4'h0, 2'd0, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            tick(st[i], bd[i], 1);
            n_tests++;
            if (obs() !== ex[i]) begin
                n_failed++;
                $display("FAIL snapshot beat %0d: got %h, want %h", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic          st [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        logic [11:0]   bd [9] = '{12'hA5C, 12'h3F1, 12'h3F1, 12'h3F1, 12'h3F1,
                                  12'h3F1, 12'h3F1, 12'h3F1, 12'h3F1};
        logic [10:0]   ex [9] = '{e(1, 4'hC, 2'd0, 0, 0), e(1, 4'h5, 2'd1, 0, 0),
                                  e(1, 4'hA, 2'd2, 1, 0), e(0, 4'h0, 2'd0, 0, 1),
                                  e(1, 4'h1, 2'd0, 0, 0), e(1, 4'hF, 2'd1, 0, 0),
                                  e(1, 4'h3, 2'd2, 1, 0), e(0, 4'h0, 2'd0, 0, 1),
                                  e(0, 4'h0, 2'd0, 0, 0)};
        for (int i = 0; i < 9; i++) begin
            tick(st[i], bd[i], 1);
            n_tests++;
            if (obs() !== ex[i]) begin
                n_failed++;
                $display("FAIL back_to_back beat %0d: got %h, want %h", i, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic          st [5] = '{1, 0, 0, 0, 0};
        logic [10:0]   ex [5] = '{e(1, 4'hC, 2'd0, 0, 0), e(1, 4'h5, 2'd1, 0, 0),
                                  e(1, 4'hA, 2'd2, 1, 0), e(0, 4'h0, 2'd0, 0, 1),
                                  e(0, 4'h0, 2'd0, 0, 0)};
        // Rows 0 and 1 handshaken; row 2 now presented.
        tick(1, 12'hA5C, 1);
        tick(0, 12'hA5C, 1);
        tick(0, 12'hA5C, 1);
        #1 reset_n_i = 1'b0;
        #1;
        n_tests++;
        if ({v_o, busy_o, start_ready_o} !== 3'b001) begin
            n_failed++;
            $display("FAIL mid_reset async: got v/busy/rdy=%b, want 001",
                     {v_o, busy_o, start_ready_o});
        end
        @(posedge clk_i);
        @(negedge clk_i);
        n_tests++;
        if ({v_o, done_o} !== 2'b00) begin
            n_failed++;
            $display("FAIL mid_reset held: got v/done=%b, want 00", {v_o, done_o});
        end
        reset_n_i = 1'b1;
        tick(0, 12'h000, 1);
        n_tests++;
        if (obs() !== e(0, 4'h0, 2'd0, 0, 0)) begin
            n_failed++;
            $display("FAIL mid_reset release: got %h, want %h", obs(), e(0, 4'h0, 2'd0, 0, 0));
        end
        for (int i = 0; i < 5; i++) begin
            tick(st[i], 12'hA5C, 1);
            n_tests++;
            if (obs() !== ex[i]) begin
                n_failed++;
                $display("FAIL mid_reset restart beat %0d: got %h, want %h", i, obs(), ex[i]);
            end
        end
    endtask

    // Reference model: a frame is a queue of pending rows {row, data}.
    // Empty queue means idle; the pop that empties it produces done next cycle.
    task automatic test_random();
        logic [5:0]   mq [$];
        logic         m_done = 1'b0;
        logic         s, rd;
        logic [11:0]  b;
        logic [10:0]  want;
        for (int cyc = 0; cyc < 400; cyc++) begin
            s  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) != 0);
            b  = 12'($urandom);
            if (mq.size() == 0) begin
                m_done = 1'b0;
                if (s) begin
                    for (int r = 0; r < H; r++) mq.push_back({2'(r), b[r*W +: W]});
                end
            end else if (rd) begin
                void'(mq.pop_front());
                m_done = (mq.size() == 0);
            end else begin
                m_done = 1'b0;
            end
            tick(s, b, rd);
            want = (mq.size() != 0) ? e(1, mq[0][3:0], mq[0][5:4], mq.size() == 1, 0)
                                    : e(0, 4'h0, 2'd0, 0, m_done);
            n_tests++;
            if (obs() !== want) begin
                n_failed++;
                $display("FAIL random cyc %0d: got %h, want %h", cyc, obs(), want);
            end
        end
        tick(0, 12'h000, 1);
        tick(0, 12'h000, 1);
    endtask

    initial begin
        reset_n_i = 1'b0;
        start_v_i = 1'b1;
        ready_i   = 1'b0;
        board_i   = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/bsg_cgol_readout.md
Name: bsg_cgol_readout

Overview:
- Reads the live state of a Game of Life cell array and streams it out one row per transfer over a valid/ready interface to the host or output path.
- On a start handshake it snapshots the full board into an internal register, then sends rows 0..board_height_p-1 in order.
- Sits downstream of the cell array; `board_i` is the concatenation of every cell's `data_o`.
- It is the read side of the array; cell loading stays on each cell's `update_i`/`update_val_i`.

Parameters:
- board_width_p, 8, cells per row; this is also the width of each output word.
- board_height_p, 8, number of rows; must be at least 1.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- start_v_i  input  1  request to snapshot and stream the board.
- start_ready_o  output  1  block is idle and can accept a start.
- board_i  input  board_width_p*board_height_p  live cell states; bit `[r*board_width_p + c]` is row r, column c (1 = alive).
- v_o  output  1  output row valid.
- ready_i  input  1  consumer accepts the row when `v_o & ready_i`.
- data_o  output  board_width_p  current row; `data_o[c]` is column c.
- row_o  output  max(1,clog2(board_height_p))  index of the current row.
- last_o  output  1  current row is the final row (`row_o == board_height_p-1`); qualified by `v_o`.
- busy_o  output  1  frame in progress.
- done_o  output  1  one-cycle pulse after the final row handshake.

Behaviour:
- Reset: asynchronous on `reset_n_i` low, released synchronously by design.
  - State goes to IDLE; row counter is 0; snapshot register is cleared to 0.
  - `v_o`=0, `busy_o`=0, `done_o`=0, `start_ready_o`=1, `data_o`=0, `row_o`=0, `last_o`=0.
- State machine, two states, registered:
  - IDLE: `start_ready_o`=1, `v_o`=0. If `start_v_i` is high at an edge, capture `board_i` into the snapshot, set row=0, go to SEND.
  - SEND: `start_ready_o`=0, `v_o`=1, `busy_o`=1.
    - `data_o`, `row_o` and `last_o` come from the snapshot and row counter only.
    - On `v_o & ready_i`: if row == board_height_p-1, go to IDLE and set `done_o`=1 for the next cycle; otherwise increment row.
- Latency:
  - First valid row appears the cycle after the start handshake.
  - With `ready_i` held high, a frame takes board_height_p consecutive cycles.
  - `done_o` is high in the first IDLE cycle after the frame.
- Backpressure: while `v_o`=1 and `ready_i`=0, `data_o`, `row_o` and `last_o` hold stable. No combinational path from `ready_i` to `v_o`.
- Snapshot isolation: `board_i` changes after the start handshake do not affect the frame in flight.
- `start_v_i` during SEND is ignored and is not queued.
- Back-to-back frames: a start may be accepted in the cycle `done_o` is high, so there is exactly one cycle with `v_o` low between frames.
- board_height_p=1: single beat with `last_o`=1; `row_o` is 1 bit, always 0.
- Row counter never exceeds board_height_p-1; no wrap-around past the final row.
- Reset mid-frame: `v_o` drops immediately, there is no `done_o`, and the partial frame is discarded. The next start restarts from row 0 with a fresh snapshot.

Test Plan:
All tests use board_width_p=4, board_height_p=3.
- Reset: `reset_n_i`=0 with `start_v_i`=1 -> `v_o`=0, `start_ready_o`=1, `busy_o`=0, `done_o`=0, `data_o`=4'h0 throughout.
- Basic frame: `board_i`=12'hA5C, start accepted, `ready_i`=1 -> next 3 cycles show `data_o`=C,5,A with `row_o`=0,1,2 and `last_o`=0,0,1; `done_o`=1 for exactly one cycle after; `busy_o` is high for the 3 beats.
- Backpressure: same frame with `ready_i`=0 for 2 cycles on row 1 -> `data_o` stays 4'h5 and `row_o` stays 1 for 3 cycles; total sequence still C,5,A with no duplicate or skipped row.
- Snapshot isolation: set `board_i`=12'h000 and pulse `start_v_i` one cycle after acceptance -> output is still C,5,A, and no second frame starts.
- Back-to-back: hold `start_v_i`=1 and change `board_i` to 12'h3F1 after the first accept -> rows C,5,A, one idle cycle with `done_o`=1 (new start accepted there), then rows 1,F,3.
- Mid-frame reset: assert `reset_n_i`=0 after the row-1 handshake -> `v_o`=0 asynchronously and no `done_o`. After release and a new start with 12'hA5C, output is C,5,A from row 0.
